// File: rtl/pulse_seq_arbiter_pkg.sv
// Shared types and sizing helpers for the phased pulse sequencer arbiter.
package pulse_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PULSE,
        POST,
        DONE
    } seq_state_t;

    // Phase counter only needs to reach the longest phase length.
    function automatic int seq_cnt_w(input int pre_cyc, input int pulse_cyc, input int post_cyc);
        int m;
        m = pre_cyc;
        if (pulse_cyc > m) m = pulse_cyc;
        if (post_cyc > m) m = post_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_seq_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface pulse_seq_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic            abort;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            busy;
    logic            pulse_out;
    logic            done;

    modport master (
        output req, abort,
        input  grant, gnt_id, busy, pulse_out, done
    );

    modport slave (
        input  req, abort,
        output grant, gnt_id, busy, pulse_out, done
    );

endinterface

// File: rtl/pulse_seq_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx,
    output logic [N-1:0]         onehot
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] k;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        k      = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = k;
            end
        end
        if (valid) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/pulse_seq_arbiter.sv
// Round-robin owner of a shared PRE -> PULSE -> POST pulse generator.
module pulse_seq_arbiter
    import pulse_seq_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int PRE_CYC   = 2,
    parameter int PULSE_CYC = 1,
    parameter int POST_CYC  = 1
) (
    input logic              clk,
    input logic              rst,
    pulse_seq_arbiter_if.slave bus
);
    localparam int IDW   = $clog2(NREQ);
    localparam int CNT_W = seq_cnt_w(PRE_CYC, PULSE_CYC, POST_CYC);

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(POST_CYC - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   rr_ptr, rr_ptr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             busy_q, pulse_q, done_q;
    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic [NREQ-1:0]  pick_onehot;
    logic [IDW-1:0]   ptr_after;

    rr_pick #(.N(NREQ)) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign ptr_after = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

    // Next state; any exit to IDLE (done, abort, bad encoding) also releases the grant.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr;
        grant_d  = grant_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                grant_d  = '0;
                gnt_id_d = '0;
                if (pick_valid) begin
                    state_d  = PRE;
                    grant_d  = pick_onehot;
                    gnt_id_d = pick_idx;
                end
            end
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = POST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            POST: begin
                if (cnt_q == POST_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                cnt_d    = '0;
                grant_d  = '0;
                gnt_id_d = '0;
                rr_ptr_d = ptr_after;
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                grant_d  = '0;
                gnt_id_d = '0;
            end
        endcase
        if (bus.abort && (state_q inside {PRE, PULSE, POST})) begin
            state_d  = IDLE;
            cnt_d    = '0;
            grant_d  = '0;
            gnt_id_d = '0;
            rr_ptr_d = ptr_after;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr   <= '0;
            grant_q  <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr   <= rr_ptr_d;
            grant_q  <= grant_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= state_d inside {PRE, PULSE, POST, DONE};
            pulse_q  <= (state_d == PULSE);
            done_q   <= (state_d == DONE);
        end
    end

    assign bus.grant     = grant_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.busy      = busy_q;
    assign bus.pulse_out = pulse_q;
    assign bus.done      = done_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_busy_grant:   assert property (@(posedge clk) disable iff (rst) busy_q == (grant_q != '0));
    a_pulse_busy:   assert property (@(posedge clk) disable iff (rst) pulse_q |-> busy_q);
    a_done_state:   assert property (@(posedge clk) disable iff (rst) done_q |-> (state_q == DONE));

endmodule
